// File: rtl/muldiv_sequencer.sv
// Sequencer for the iterative Mult/Div units behind HI/LO: runs the selected unit for a
// fixed cycle count, then writes HI/LO; divide-by-zero is flagged before Div is started.
module muldiv_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start_Mult,
   input  logic        Start_Div,
   input  logic        Abort,
   input  logic [31:0] Divisor,
   output logic        Mult_Control,
   output logic        Div_Control,
   output logic        HI_Src,
   output logic        LO_Src,
   output logic        HI_Write,
   output logic        LO_Write,
   output logic        Busy,
   output logic        Done,
   output logic        Div_Zero
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] MULT_RUN  = 3'd1;
   localparam logic [2:0] DIV_RUN   = 3'd2;
   localparam logic [2:0] WRITEBACK = 3'd3;
   localparam logic [2:0] DZERO     = 3'd4;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             sel;

   // Abort outranks any start seen in the same cycle; the counter only loads in IDLE
   // and only counts down in the RUN states, so it can never wrap.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= IDLE;
         cnt   <= '0;
         sel   <= 1'b0;
      end else if (Abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (Start_Mult) begin
                  state <= MULT_RUN;
                  cnt   <= MULT_LOAD;
                  sel   <= 1'b0;
               end else if (Start_Div) begin
                  if (Divisor == 32'd0) begin
                     state <= DZERO;
                  end else begin
                     state <= DIV_RUN;
                     cnt   <= DIV_LOAD;
                     sel   <= 1'b1;
                  end
               end
            end
            MULT_RUN, DIV_RUN: begin
               if (cnt == '0) state <= WRITEBACK;
               else           cnt   <= cnt - CNT_ONE;
            end
            WRITEBACK: state <= IDLE;
            DZERO:     state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   assign Mult_Control = (state == MULT_RUN);
   assign Div_Control  = (state == DIV_RUN);
   assign HI_Write     = (state == WRITEBACK);
   assign LO_Write     = (state == WRITEBACK);
   assign Done         = (state == WRITEBACK);
   assign Div_Zero     = (state == DZERO);
   assign Busy         = (state != IDLE);
   // Source selects hold the last accepted operation so they are stable at WRITEBACK.
   assign HI_Src       = sel;
   assign LO_Src       = sel;

endmodule
